// File: rtl/uart_rx_framed.sv
// uart_rx_framed
//   RS-232 receiver with configurable frame format (5-9 data bits, none/odd/even
//   parity, 1 or 2 stop bits), 3-sample mid-bit majority voting, per-word error
//   flags, break detection and a one-word holding register with valid/ready.
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   RxD             serial line (idle high, asynchronous to clk)
//   data_out        received word, stable while data_valid
//   data_valid      holding register full
//   data_ready      consumer takes the word when data_valid & data_ready
//   parity_err      parity mismatch for the held word
//   frame_err       a stop-bit vote was 0 for the held word
//   break_det       held word was a break (every vote 0)
//   overrun         held word overwrote an unaccepted one
//   rx_busy         frame reception in progress
module uart_rx_framed #(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int Oversampling = 16,
    parameter int DataBits     = 8,
    parameter int Parity       = 0,
    parameter int StopBits     = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RxD,
    output logic [DataBits-1:0] data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                parity_err,
    output logic                frame_err,
    output logic                break_det,
    output logic                overrun,
    output logic                rx_busy
);

    localparam longint TickRate = longint'(Baud) * longint'(Oversampling);
    localparam int     AccW     = $clog2(ClkFrequency) + 2;
    localparam int     CntW     = $clog2(Oversampling);

    if (longint'(ClkFrequency) < TickRate || Oversampling < 8 ||
        (Oversampling & (Oversampling - 1)) != 0 ||
        DataBits < 5 || DataBits > 9 || Parity < 0 || Parity > 2 ||
        (StopBits != 1 && StopBits != 2)) begin : g_param_check
        $error("uart_rx_framed: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
    } state_t;

    state_t              state_q, state_d;
    logic [AccW-1:0]     acc_q, acc_d, acc_sum;
    logic                tick_q, tick_d;
    logic [1:0]          sync_q, sync_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cur;
    logic [CntW-1:0]     hi_cnt_q, hi_cnt_d;
    logic [1:0]          samp_q, samp_d;
    logic [DataBits-1:0] shreg_q, shreg_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic                stop_cnt_q, stop_cnt_d;
    logic                par_q, par_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                zero_q, zero_d;
    logic [DataBits-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_out_q, perr_out_d;
    logic                ferr_out_q, ferr_out_d;
    logic                brk_q, brk_d;
    logic                ovr_q, ovr_d;
    logic                busy_q, busy_d;

    logic rx_s, vote, complete, zero_fin, ferr_fin;

    assign rx_s = sync_q[1];
    assign cur  = cnt_q + 1'b1;   // tick index within the bit, wraps at Oversampling
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_cnt_d   = hi_cnt_q;
        samp_d     = samp_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        zero_d     = zero_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        brk_d      = brk_q;
        ovr_d      = ovr_q;
        complete   = 1'b0;
        zero_fin   = 1'b0;
        ferr_fin   = 1'b0;

        sync_d  = {sync_q[0], RxD};

        // Fractional baud accumulator: the average tick rate is exact, jitter is one clk.
        acc_sum = acc_q + AccW'(TickRate);
        tick_d  = (acc_sum >= AccW'(ClkFrequency));
        acc_d   = tick_d ? acc_sum - AccW'(ClkFrequency) : acc_sum;

        if (tick_q) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_BRKWAIT: begin
                    // Leave only after a full bit time of uninterrupted high line.
                    if (rx_s) begin
                        if (hi_cnt_q == CntW'(Oversampling - 1)) state_d = S_IDLE;
                        hi_cnt_d = hi_cnt_q + 1'b1;
                    end else begin
                        hi_cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d = cur;
                    if (cur == CntW'(Oversampling / 2 - 1)) samp_d[0] = rx_s;
                    if (cur == CntW'(Oversampling / 2))     samp_d[1] = rx_s;
                    if (cur == CntW'(Oversampling / 2 + 1)) begin
                        case (state_q)
                            S_START: begin
                                if (vote) begin
                                    state_d = S_IDLE;   // glitch, drop silently
                                end else begin
                                    state_d   = S_DATA;
                                    bit_cnt_d = '0;
                                    par_d     = 1'b0;
                                    perr_d    = 1'b0;
                                    ferr_d    = 1'b0;
                                    zero_d    = 1'b1;
                                end
                            end
                            S_DATA: begin
                                shreg_d = {vote, shreg_q[DataBits-1:1]};
                                par_d   = par_q ^ vote;
                                zero_d  = zero_q & ~vote;
                                if (bit_cnt_q == 4'(DataBits - 1)) begin
                                    state_d    = (Parity != 0) ? S_PARITY : S_STOP;
                                    stop_cnt_d = 1'b0;
                                end else begin
                                    bit_cnt_d = bit_cnt_q + 1'b1;
                                end
                            end
                            S_PARITY: begin
                                // odd: data^p must be 1; even: must be 0
                                perr_d     = (Parity == 1) ? ~(par_q ^ vote) : (par_q ^ vote);
                                zero_d     = zero_q & ~vote;
                                state_d    = S_STOP;
                                stop_cnt_d = 1'b0;
                            end
                            S_STOP: begin
                                zero_fin = zero_q & ~vote;
                                ferr_fin = ferr_q | ~vote;
                                zero_d   = zero_fin;
                                ferr_d   = ferr_fin;
                                if (stop_cnt_q == 1'(StopBits - 1)) begin
                                    complete = 1'b1;
                                    state_d  = zero_fin ? S_BRKWAIT : S_IDLE;
                                    hi_cnt_d = '0;
                                end else begin
                                    stop_cnt_d = 1'b1;
                                end
                            end
                            default: state_d = S_IDLE;
                        endcase
                    end
                end
            endcase
        end

        // Holding register: a completing frame wins over acceptance in the same cycle.
        if (complete) begin
            data_d     = zero_fin ? '0 : shreg_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_fin;
            brk_d      = zero_fin;
            ovr_d      = valid_q & ~data_ready;
            valid_d    = 1'b1;
        end else if (valid_q && data_ready) begin
            valid_d    = 1'b0;
            perr_out_d = 1'b0;
            ferr_out_d = 1'b0;
            brk_d      = 1'b0;
            ovr_d      = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            tick_q     <= 1'b0;
            sync_q     <= 2'b11;
            cnt_q      <= '0;
            hi_cnt_q   <= '0;
            samp_q     <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            zero_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            tick_q     <= tick_d;
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            samp_q     <= samp_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            zero_q     <= zero_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_out_q;
    assign frame_err  = ferr_out_q;
    assign break_det  = brk_q;
    assign overrun    = ovr_q;
    assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench: 16 clk per bit (1 tick per clk). u_dut0 is 8N1, u_dut1 is 7E2.
module tb_uart_rx_framed;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       rxd0 = 1'b1, rdy0 = 1'b1;
    logic [7:0] d0;
    logic       v0, pe0, fe0, bk0, ov0, by0;

    logic       rxd1 = 1'b1, rdy1 = 1'b1;
    logic [6:0] d1;
    logic       v1, pe1, fe1, bk1, ov1, by1;

    uart_rx_framed #(.ClkFrequency(1600000), .Baud(100000), .Oversampling(16),
                     .DataBits(8), .Parity(0), .StopBits(1)) u_dut0 (
        .clk(clk), .rst(rst), .RxD(rxd0), .data_out(d0), .data_valid(v0),
        .data_ready(rdy0), .parity_err(pe0), .frame_err(fe0), .break_det(bk0),
        .overrun(ov0), .rx_busy(by0));

    uart_rx_framed #(.ClkFrequency(1600000), .Baud(100000), .Oversampling(16),
                     .DataBits(7), .Parity(2), .StopBits(2)) u_dut1 (
        .clk(clk), .rst(rst), .RxD(rxd1), .data_out(d1), .data_valid(v1),
        .data_ready(rdy1), .parity_err(pe1), .frame_err(fe1), .break_det(bk1),
        .overrun(ov1), .rx_busy(by1));

    int n_chk = 0, n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every accepted word (accept condition is stable at negedge).
    int         w0 = 0, w1 = 0, c0_cyc = 0;
    logic [7:0] c0_d = '0;
    logic [6:0] c1_d = '0;
    logic [3:0] c0_f = '0, c1_f = '0;  // {overrun, break, frame, parity}
    always @(negedge clk) begin
        if (v0 && rdy0) begin
            w0 <= w0 + 1; c0_d <= d0; c0_f <= {ov0, bk0, fe0, pe0}; c0_cyc <= cyc;
        end
        if (v1 && rdy1) begin
            w1 <= w1 + 1; c1_d <= d1; c1_f <= {ov1, bk1, fe1, pe1};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive n line bits LSB first, 16 clk each; call and return at posedge+1.
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) rxd0 = bits[i];
            else          rxd1 = bits[i];
            repeat (16) @(posedge clk);
            #1;
        end
    endtask

    task automatic send8(input logic [7:0] b);
        send_bits(0, {7'h7f, 1'b1, b, 1'b0}, 10);
    endtask

    int base, t0, n;

    initial begin
        @(posedge clk); #1;
        idle(2);
        chk("rst_valid", v0, 0);
        chk("rst_data", d0, 0);
        chk("rst_busy", by0, 0);
        chk("rst_flags", {ov0, bk0, fe0, pe0}, 0);
        rst = 1'b0;
        idle(20);

        // 1: 8N1 0xA5, latency from start edge to valid
        base = w0; t0 = cyc;
        send8(8'hA5);
        idle(20);
        chk("t1_words", w0 - base, 1);
        chk("t1_data", c0_d, 8'hA5);
        chk("t1_flags", c0_f, 0);
        chk("t1_latency", c0_cyc - t0, 156);
        chk("t1_valid_low", v0, 0);

        // 2: 7E2, 0x41 has even parity bit 0
        base = w1;
        send_bits(1, {5'h00, 2'b11, 1'b0, 7'h41, 1'b0}, 11);
        idle(32);
        chk("t2a_data", c1_d, 7'h41);
        chk("t2a_flags", c1_f, 0);
        send_bits(1, {5'h00, 2'b11, 1'b1, 7'h41, 1'b0}, 11);
        idle(32);
        chk("t2b_data", c1_d, 7'h41);
        chk("t2b_flags", c1_f, 4'b0001);
        send_bits(1, {5'h00, 2'b01, 1'b0, 7'h41, 1'b0}, 11);
        rxd1 = 1'b1;
        idle(48);
        chk("t2c_flags", c1_f, 4'b0010);
        chk("t2_words", w1 - base, 3);
        chk("t2_busy", by1, 0);

        // 3: 6-clk glitch
        base = w0;
        rxd0 = 1'b0;
        idle(6);
        rxd0 = 1'b1;
        chk("t3_busy_hi", by0, 1);
        n = 0;
        while (by0 && n < 10) begin idle(1); n++; end
        chk("t3_busy_drop", (n <= 9) ? 1 : 0, 1);
        idle(40);
        chk("t3_words", w0 - base, 0);

        // 4: break 30 bit times, short high does not rearm, then 0x55
        base = w0;
        rxd0 = 1'b0;
        idle(480);
        chk("t4_words", w0 - base, 1);
        chk("t4_data", c0_d, 0);
        chk("t4_flags", c0_f, 4'b0110);
        rxd0 = 1'b1;
        idle(8);
        rxd0 = 1'b0;
        idle(200);
        chk("t4_no_rearm", w0 - base, 1);
        rxd0 = 1'b1;
        idle(30);
        send8(8'h55);
        idle(20);
        chk("t4_next_words", w0 - base, 2);
        chk("t4_next_data", c0_d, 8'h55);
        chk("t4_next_flags", c0_f, 0);

        // 5: overrun
        rdy0 = 1'b0;
        send8(8'h11);
        idle(16);
        chk("t5_first_valid", v0, 1);
        chk("t5_first_data", d0, 8'h11);
        chk("t5_first_ovr", ov0, 0);
        send8(8'h22);
        idle(16);
        chk("t5_data", d0, 8'h22);
        chk("t5_ovr", ov0, 1);
        chk("t5_valid", v0, 1);
        rdy0 = 1'b1;
        idle(1);
        chk("t5_valid_drop", v0, 0);
        chk("t5_ovr_clr", ov0, 0);
        chk("t5_cap", {c0_f[3], c0_d}, {1'b1, 8'h22});

        // 6: reset mid-frame of 0x3C
        base = w0;
        send_bits(0, 16'b1000, 4);
        chk("t6_busy_mid", by0, 1);
        rst = 1'b1;
        idle(3);
        chk("t6_rst_busy", by0, 0);
        chk("t6_rst_valid", v0, 0);
        chk("t6_rst_data", d0, 0);
        rxd0 = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(40);
        chk("t6_no_word", w0 - base, 0);
        send8(8'hC3);
        idle(20);
        chk("t6_words", w0 - base, 1);
        chk("t6_data", c0_d, 8'hC3);
        chk("t6_flags", c0_f, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
